// File: rtl/hid_pkg.sv
// Shared command codes, version bytes and quadrature helpers for the HID bridge.
// Pure definitions: no latency, no flow control.
package hid_pkg;

   typedef enum logic [7:0] {
      CMD_STATUS = 8'h00,
      CMD_KBD    = 8'h01,
      CMD_MOUSE  = 8'h02,
      CMD_JOY    = 8'h03,
      CMD_DB9    = 8'h04,
      CMD_QSTAT  = 8'h05
   } hid_cmd_e;

   localparam logic [7:0] HID_VERSION    = 8'h02;
   localparam logic [7:0] HID_SUBVERSION = 8'h00;

   localparam int QUAD_W  = 2;
   localparam int MOUSE_W = 1 + 2 * QUAD_W;

   // Forward order is 00->01->11->10->00; fwd=0 walks it backwards.
   function automatic logic [QUAD_W-1:0] quad_step(input logic [QUAD_W-1:0] q, input logic fwd);
      case (q)
         2'b00:   return fwd ? 2'b01 : 2'b10;
         2'b01:   return fwd ? 2'b11 : 2'b00;
         2'b11:   return fwd ? 2'b10 : 2'b01;
         default: return fwd ? 2'b00 : 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/hid_kbd_fifo.sv
// First-word-fall-through keyboard event FIFO; head visible the cycle after a push into empty.
// Push while full is dropped (sticky overflow) unless a pop happens in the same cycle.
module hid_kbd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic [7:0] push_dat_i,
   input  logic       pop_rdy_i,
   input  logic       ovf_clr_i,
   output logic [7:0] head_dat_o,
   output logic       empty_o,
   output logic       full_o,
   output logic [6:0] level_o,
   output logic       ovf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [6:0] DEPTH_L = 7'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [6:0]    level_q, level_d;
   logic          ovf_q, ovf_d;
   logic          full, empty, pop, wr_en;

   assign full  = (level_q == DEPTH_L);
   assign empty = (level_q == 7'd0);
   assign pop   = ~empty & pop_rdy_i;
   assign wr_en = push_i & (~full | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, pop})
         2'b10:   level_d = level_q + 7'd1;
         2'b01:   level_d = level_q - 7'd1;
         default: level_d = level_q;
      endcase
      // A drop in the same cycle as a clear must stay visible.
      if (push_i & full & ~pop) ovf_d = 1'b1;
      else if (ovf_clr_i)       ovf_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_dat_o = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign empty_o    = empty;
   assign full_o     = full;
   assign level_o    = level_q;
   assign ovf_o      = ovf_q;

endmodule

// File: rtl/hid_bridge.sv
// MCU byte-channel HID bridge: keyboard FIFO, saturating quadrature mouse, joysticks, db9 irq.
// Responses registered one cycle after the strobe; keyboard output is valid/ready, other paths never stall.
module hid_bridge
   import hid_pkg::*;
#(
   parameter int NUM_JOY   = 2,
   parameter int KBD_DEPTH = 8,
   parameter int MOUSE_DIV = 4096,
   parameter int ACC_W     = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   data_in_strobe,
   input  logic                   data_in_start,
   input  logic [7:0]             data_in,
   output logic [7:0]             data_out,
   input  logic [5:0]             db9_port,
   output logic                   irq,
   input  logic                   iack,
   output logic [MOUSE_W-1:0]     mouse,
   output logic                   kbd_valid,
   output logic [7:0]             kbd_code,
   input  logic                   kbd_ready,
   output logic [8*NUM_JOY-1:0]   joystick
);

   localparam int DW = $clog2(MOUSE_DIV);
   localparam int SW = ACC_W + 2;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic [7:0] d);
      logic signed [SW-1:0] s;
      s = SW'(a) + SW'($signed(d));
      if (s > SW'(ACC_MAX)) return ACC_MAX;
      if (s < SW'(ACC_MIN)) return ACC_MIN;
      return ACC_W'(s);
   endfunction

   logic [7:0]              cmd_q, cmd_d, data_out_q, data_out_d, sel_q, sel_d;
   logic [3:0]              idx_q, idx_d;
   logic [8*NUM_JOY-1:0]    joy_q, joy_d;
   logic                    btn_q, btn_d;
   logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic [QUAD_W-1:0]       qx_q, qx_d, qy_q, qy_d;
   logic [DW-1:0]           div_q;
   logic [5:0]              db9_s1_q, db9_sync_q, db9_prev_q;
   logic                    irq_q, irq_d, irq_en_q, irq_en_d;

   logic       byte_vld, div_wrap, arm, irq_set, kbd_push, ovf_clr;
   logic [7:0] dx, dy;
   logic       kbd_empty, kbd_full, kbd_ovf;
   logic [6:0] kbd_level;

   assign byte_vld = data_in_strobe & ~data_in_start;
   assign div_wrap = (div_q == DW'(MOUSE_DIV - 1));
   assign kbd_push = byte_vld && (cmd_q == CMD_KBD);
   assign ovf_clr  = byte_vld && (cmd_q == CMD_QSTAT) && (idx_q == 4'd0);
   assign arm      = byte_vld && (cmd_q == CMD_DB9) && (idx_q == 4'd0);
   assign dx       = (byte_vld && cmd_q == CMD_MOUSE && idx_q == 4'd1) ? data_in : 8'h00;
   assign dy       = (byte_vld && cmd_q == CMD_MOUSE && idx_q == 4'd2) ? data_in : 8'h00;
   assign irq_set  = irq_en_q & (db9_sync_q != db9_prev_q);

   always_comb begin
      cmd_d      = cmd_q;
      idx_d      = idx_q;
      data_out_d = data_out_q;
      sel_d      = sel_q;
      joy_d      = joy_q;
      btn_d      = btn_q;
      if (data_in_strobe && data_in_start) begin
         cmd_d = data_in;
         idx_d = 4'd0;
      end else if (byte_vld) begin
         if (idx_q != 4'hF) idx_d = idx_q + 4'd1;
         case (cmd_q)
            CMD_STATUS: begin
               case (idx_q)
                  4'd0:    data_out_d = HID_VERSION;
                  4'd1:    data_out_d = HID_SUBVERSION;
                  4'd2:    data_out_d = 8'(NUM_JOY);
                  4'd3:    data_out_d = 8'(KBD_DEPTH);
                  default: data_out_d = data_out_q;
               endcase
            end
            CMD_MOUSE: if (idx_q == 4'd0) btn_d = data_in[0];
            CMD_JOY: begin
               if (idx_q == 4'd0) sel_d = data_in;
               else if (idx_q == 4'd1) begin
                  for (int i = 0; i < NUM_JOY; i++)
                     if (sel_q == 8'(i)) joy_d[8*i +: 8] = data_in;
               end
            end
            CMD_DB9:   data_out_d = {2'b00, db9_sync_q};
            CMD_QSTAT: if (idx_q == 4'd0) data_out_d = {kbd_ovf, kbd_level};
            default:   data_out_d = data_out_q;
         endcase
      end
   end

   // Delta add and decay step compose in one cycle; direction follows the post-add sign.
   always_comb begin
      acc_x_d = sat_add(acc_x_q, dx);
      acc_y_d = sat_add(acc_y_q, dy);
      qx_d    = qx_q;
      qy_d    = qy_q;
      if (div_wrap) begin
         if (acc_x_d != '0) begin
            qx_d    = quad_step(qx_q, ~acc_x_d[ACC_W-1]);
            acc_x_d = acc_x_d[ACC_W-1] ? acc_x_d + ACC_W'(1) : acc_x_d - ACC_W'(1);
         end
         if (acc_y_d != '0) begin
            qy_d    = quad_step(qy_q, acc_y_d[ACC_W-1]);
            acc_y_d = acc_y_d[ACC_W-1] ? acc_y_d + ACC_W'(1) : acc_y_d - ACC_W'(1);
         end
      end
   end

   always_comb begin
      irq_d    = irq_set | (irq_q & ~iack);
      irq_en_d = irq_set ? 1'b0 : (arm ? 1'b1 : irq_en_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_q      <= 8'h00;
         idx_q      <= 4'd0;
         data_out_q <= 8'h00;
         sel_q      <= 8'h00;
         joy_q      <= '0;
         btn_q      <= 1'b0;
         acc_x_q    <= '0;
         acc_y_q    <= '0;
         qx_q       <= '0;
         qy_q       <= '0;
         div_q      <= '0;
         db9_s1_q   <= '0;
         db9_sync_q <= '0;
         db9_prev_q <= '0;
         irq_q      <= 1'b0;
         irq_en_q   <= 1'b0;
      end else begin
         cmd_q      <= cmd_d;
         idx_q      <= idx_d;
         data_out_q <= data_out_d;
         sel_q      <= sel_d;
         joy_q      <= joy_d;
         btn_q      <= btn_d;
         acc_x_q    <= acc_x_d;
         acc_y_q    <= acc_y_d;
         qx_q       <= qx_d;
         qy_q       <= qy_d;
         div_q      <= div_wrap ? '0 : div_q + DW'(1);
         db9_s1_q   <= db9_port;
         db9_sync_q <= db9_s1_q;
         db9_prev_q <= db9_sync_q;
         irq_q      <= irq_d;
         irq_en_q   <= irq_en_d;
      end
   end

   hid_kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
      .clk_i      (clk),
      .rst_i      (reset),
      .push_i     (kbd_push),
      .push_dat_i (data_in),
      .pop_rdy_i  (kbd_ready),
      .ovf_clr_i  (ovf_clr),
      .head_dat_o (kbd_code),
      .empty_o    (kbd_empty),
      .full_o     (kbd_full),
      .level_o    (kbd_level),
      .ovf_o      (kbd_ovf)
   );

   // A full FIFO always reports a non-empty head.
   assign kbd_valid = ~kbd_empty | kbd_full;
   assign data_out  = data_out_q;
   assign irq       = irq_q;
   assign mouse     = {~btn_q, qx_q, qy_q};
   assign joystick  = joy_q;

endmodule
